// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction fetch stage with a two-state (IDLE/RUN) controller. It drives
//   the PC to instruction memory and registers the returned word for
//   decode. Redirects from execute override stall and run. Instruction words
//   are passed through undecoded.
//
// Ports:
//   clk       in   1   rising-edge clock
//   n_rst     in   1   asynchronous active-low reset
//   run       in   1   1 = fetching enabled, 0 = hold PC / go idle
//   stall     in   1   downstream not ready: freeze PC and instruction reg
//   jmp_en    in   1   redirect request (single-cycle pulse)
//   jmp_addr  in   8   redirect target PC
//   im_dout   in  13   instruction word read combinationally at im_addr
//   im_addr   out  8   fetch address (the PC register itself)
//   ir        out 13   registered instruction for decode
//   ir_pc     out  8   address the current ir was fetched from
//   ir_valid  out  1   ir holds a live instruction
//   state     out  1   0 = IDLE, 1 = RUN
// ---------------------------------------------------------------------------
module fetch_stage (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        run,
    input  logic        stall,
    input  logic        jmp_en,
    input  logic [7:0]  jmp_addr,
    input  logic [12:0] im_dout,
    output logic [7:0]  im_addr,
    output logic [12:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    output logic        state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_pc;
    logic [12:0] r_ir;
    logic [7:0]  r_ir_pc;
    logic        r_ir_valid;

    logic [7:0]  w_pc_nxt;
    logic [12:0] w_ir_nxt;
    logic [7:0]  w_ir_pc_nxt;
    logic        w_ir_valid_nxt;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_pc       <= 8'd0;
            r_ir       <= 13'd0;
            r_ir_pc    <= 8'd0;
            r_ir_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_pc    <= w_ir_pc_nxt;
            r_ir_valid <= w_ir_valid_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. A jump pins the state for that edge, so a redirect
    // taken while idle leaves the block idle.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        if (!jmp_en) begin
            case (r_state)
                IDLE:    if (run)  w_state_nxt = RUN;
                RUN:     if (!run) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_ir_pc_nxt    = r_ir_pc;
        w_ir_valid_nxt = r_ir_valid;

        if (jmp_en) begin
            // Redirect wins over stall and run; the word at the old PC is
            // squashed and ir_pc keeps pointing at the last real fetch.
            w_pc_nxt       = jmp_addr;
            w_ir_nxt       = 13'd0;
            w_ir_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Includes the IDLE->RUN edge: no fetch happens here.
                    w_ir_valid_nxt = 1'b0;
                end
                RUN: begin
                    if (!run) begin
                        w_ir_valid_nxt = 1'b0;
                    end else if (!stall) begin
                        w_ir_nxt       = im_dout;
                        w_ir_pc_nxt    = r_pc;
                        w_ir_valid_nxt = 1'b1;
                        w_pc_nxt       = r_pc + 8'd1;  // wraps 255 -> 0
                    end
                end
                default: begin
                    w_ir_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign im_addr  = r_pc;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;
    assign state    = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A 256-entry instruction memory model is
// read combinationally at im_addr. Addresses 0..3 hold the program words;
// every other address holds 13'h1000 | addr so the fetched word identifies
// its address.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        n_rst;
    logic        run;
    logic        stall;
    logic        jmp_en;
    logic [7:0]  jmp_addr;
    logic [12:0] im_dout;
    logic [7:0]  im_addr;
    logic [12:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        state;

    logic [12:0] mem [256];

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .run      (run),
        .stall    (stall),
        .jmp_en   (jmp_en),
        .jmp_addr (jmp_addr),
        .im_dout  (im_dout),
        .im_addr  (im_addr),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .state    (state)
    );

    assign im_dout = mem[im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ir(input string tag, input logic [12:0] e_ir,
                            input logic [7:0] e_pc, input logic e_v,
                            input logic [7:0] e_addr);
        check({tag, ".ir"},       32'(ir),       32'(e_ir));
        check({tag, ".ir_pc"},    32'(ir_pc),    32'(e_pc));
        check({tag, ".ir_valid"}, 32'(ir_valid), 32'(e_v));
        check({tag, ".im_addr"},  32'(im_addr),  32'(e_addr));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 13'h1000 | 13'(i);
        mem[0] = 13'h0700;
        mem[1] = 13'h06CE;
        mem[2] = 13'h0C00;
        mem[3] = 13'h0F01;

        n_rst    = 1'b0;
        run      = 1'b0;
        stall    = 1'b0;
        jmp_en   = 1'b0;
        jmp_addr = 8'd0;

        // Reset state
        #12;
        check_ir("rst", 13'h0000, 8'd0, 1'b0, 8'd0);
        check("rst.state", 32'(state), 32'd0);

        // Basic fetch: release, run=1; first edge is the idle->run edge
        @(negedge clk);
        n_rst = 1'b1;
        run   = 1'b1;
        step();
        check("go.state", 32'(state), 32'd1);
        check_ir("go", 13'h0000, 8'd0, 1'b0, 8'd0);
        step();
        check_ir("f0", 13'h0700, 8'd0, 1'b1, 8'd1);
        step();
        check_ir("f1", 13'h06CE, 8'd1, 1'b1, 8'd2);
        step();
        check_ir("f2", 13'h0C00, 8'd2, 1'b1, 8'd3);

        // Stall for three edges: everything frozen, ir_valid stays high
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_ir("stall", 13'h0C00, 8'd2, 1'b1, 8'd3);
        end
        stall = 1'b0;
        step();
        check_ir("f3", 13'h0F01, 8'd3, 1'b1, 8'd4);

        // Jump to 1 while ir=0x0F01
        jmp_en   = 1'b1;
        jmp_addr = 8'd1;
        step();
        check_ir("jmp", 13'h0000, 8'd3, 1'b0, 8'd1);
        jmp_en = 1'b0;
        step();
        check_ir("jmp1", 13'h06CE, 8'd1, 1'b1, 8'd2);

        // Jump during stall: redirect still happens
        stall    = 1'b1;
        jmp_en   = 1'b1;
        jmp_addr = 8'd200;
        step();
        check_ir("stjmp", 13'h0000, 8'd1, 1'b0, 8'd200);
        stall = 1'b0;

        // Back-to-back jumps: last target wins, ir_valid stays low
        jmp_addr = 8'd10;
        step();
        check_ir("bb0", 13'h0000, 8'd1, 1'b0, 8'd10);
        jmp_addr = 8'd254;
        step();
        check_ir("bb1", 13'h0000, 8'd1, 1'b0, 8'd254);
        jmp_en = 1'b0;

        // Wrap-around: 254, 255, 0, 1 with no gap
        step();
        check_ir("w254", 13'h10FE, 8'd254, 1'b1, 8'd255);
        step();
        check_ir("w255", 13'h10FF, 8'd255, 1'b1, 8'd0);
        step();
        check_ir("w0", 13'h0700, 8'd0, 1'b1, 8'd1);
        step();
        check_ir("w1", 13'h06CE, 8'd1, 1'b1, 8'd2);

        // Run toggling
        run = 1'b0;
        step();
        check("off.state", 32'(state), 32'd0);
        check_ir("off", 13'h06CE, 8'd1, 1'b0, 8'd2);
        step();
        check_ir("idle", 13'h06CE, 8'd1, 1'b0, 8'd2);
        run = 1'b1;
        step();
        check("on.state", 32'(state), 32'd1);
        check_ir("on", 13'h06CE, 8'd1, 1'b0, 8'd2);
        step();
        check_ir("resume", 13'h0C00, 8'd2, 1'b1, 8'd3);

        // Jump while idle: PC loads, state stays idle
        run = 1'b0;
        step();
        jmp_en   = 1'b1;
        jmp_addr = 8'd3;
        run      = 1'b1;
        step();
        check("ijmp.state", 32'(state), 32'd0);
        check_ir("ijmp", 13'h0000, 8'd2, 1'b0, 8'd3);
        jmp_en = 1'b0;
        step();
        check("ijmp2.state", 32'(state), 32'd1);
        step();
        check_ir("ijmp3", 13'h0F01, 8'd3, 1'b1, 8'd4);

        // Reset mid-operation during stall with a jump pending
        stall    = 1'b1;
        jmp_en   = 1'b1;
        jmp_addr = 8'h55;
        #2;
        n_rst = 1'b0;
        #1;
        check_ir("arst", 13'h0000, 8'd0, 1'b0, 8'd0);
        check("arst.state", 32'(state), 32'd0);
        step();
        check_ir("arst_hold", 13'h0000, 8'd0, 1'b0, 8'd0);
        @(negedge clk);
        n_rst  = 1'b1;
        stall  = 1'b0;
        jmp_en = 1'b0;
        step();
        check("rel.state", 32'(state), 32'd1);
        check_ir("rel", 13'h0000, 8'd0, 1'b0, 8'd0);
        step();
        check_ir("rel_f0", 13'h0700, 8'd0, 1'b1, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
